// File: rtl/ysyx_22040125_ifu.sv
// Instruction fetch unit: owns the PC, issues one 8-byte-aligned imem read at a
// time, selects the 32-bit word addressed by pc[2] and hands it to decode over
// a valid/ready handshake. Execute may redirect fetch at any point; a redirect
// that races an in-flight request marks the response as stale via `kill`.
module ysyx_22040125_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic        kill, kill_n;
  logic [31:0] inst_n;
  logic [63:0] inst_pc_n;
  logic        inst_valid_n;
  logic [63:0] redirect_aligned;

  // Instructions are 4-byte aligned, so the low two bits of a redirect target are dropped.
  assign redirect_aligned = redirect_pc & ~64'h3;

  // The request is a pure function of state and PC so a redirect shows up on the bus next cycle.
  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc & ~64'h7;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      inst       <= 32'h0;
      inst_pc    <= 64'h0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      kill       <= kill_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
      inst_valid <= inst_valid_n;
    end
  end

  // Next-state and datapath updates; redirect outranks every other event except in HALT.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    kill_n       = kill;
    inst_n       = inst;
    inst_pc_n    = inst_pc;
    inst_valid_n = inst_valid;
    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_n = redirect_aligned;
          if (imem_req_ready) begin
            // The old address was accepted this cycle; its data must be thrown away.
            state_n = S_WAIT;
            kill_n  = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_aligned;
          if (imem_resp_valid) begin
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            kill_n = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            inst_n       = pc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
            inst_pc_n    = pc;
            inst_valid_n = 1'b1;
            pc_n         = pc + 64'd4;
            state_n      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_n         = redirect_aligned;
          inst_valid_n = 1'b0;
          state_n      = S_REQ;
        end else if (inst_ready) begin
          inst_valid_n = 1'b0;
          state_n      = halt ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        inst_valid_n = 1'b0;
      end
      default: begin
        state_n = S_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040125_ifu.sv
// Bench for the fetch unit: a scoreboard queue holds {inst, pc} expected for each
// response the bench returns, and a monitor pops/compares on every decode handshake.
module tb_ysyx_22040125_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [63:0] imem_resp_data = 64'h0;
  logic        inst_ready = 1'b0;
  logic        inst_ready2 = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        halt = 1'b0;

  logic        imem_req_valid, req_valid2;
  logic [63:0] imem_req_addr, req_addr2;
  logic        inst_valid, inst_valid2;
  logic [31:0] inst, inst2;
  logic [63:0] inst_pc, inst_pc2;

  int checks = 0;
  int failures = 0;
  logic [95:0] sb[$];
  logic [63:0] mpc;

  ysyx_22040125_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
  );

  ysyx_22040125_ifu #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready),
    .imem_req_addr(req_addr2), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid2),
    .inst_ready(inst_ready2), .inst(inst2), .inst_pc(inst_pc2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h00000013_00100093;
    return {a[31:0] ^ 32'h1357_9BDF, a[31:0] + 32'h0000_0013};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory side of one fetch: accept the request now, answer after k cycles.
  task automatic serve(input int k, input logic use_ovr, input logic [63:0] ovr);
    logic [63:0] a;
    logic [63:0] d;
    logic [31:0] ei;
    a = imem_req_addr;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    repeat (k - 1) tick();
    d = use_ovr ? ovr : mem_data(a);
    ei = mpc[2] ? d[63:32] : d[31:0];
    sb.push_back({ei, mpc});
    mpc = mpc + 64'd4;
    imem_resp_valid = 1'b1;
    imem_resp_data = d;
    tick();
    imem_resp_valid = 1'b0;
  endtask

  // Scoreboard monitor: every consumed instruction must match the oldest expected one.
  always @(negedge clk) begin
    logic [95:0] e;
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected inst=%h pc=%h required=none", inst, inst_pc);
      end else begin
        e = sb.pop_front();
        if ({inst, inst_pc} !== e) begin
          failures++;
          $display("FAIL sb_inst got inst=%h pc=%h required inst=%h pc=%h", inst, inst_pc, e[95:64], e[63:0]);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({inst_valid, inst, inst_pc} !== {1'b0, 32'h0, 64'h0}) begin
      failures++;
      $display("FAIL reset_outputs got v=%b inst=%h pc=%h required 0/0/0", inst_valid, inst, inst_pc);
    end
    rst = 1'b0;
    mpc = 64'h8000_0000;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0000}) begin
      failures++;
      $display("FAIL reset_req got v=%b addr=%h required 1/80000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_basic();
    inst_ready = 1'b0;
    serve(1, 1'b0, 64'h0);
    checks++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h00100093, 64'h8000_0000}) begin
      failures++;
      $display("FAIL basic_first got v=%b inst=%h pc=%h required 1/00100093/80000000", inst_valid, inst, inst_pc);
    end
    inst_ready = 1'b1;
    tick();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0000}) begin
      failures++;
      $display("FAIL basic_req2 got v=%b addr=%h required 1/80000000", imem_req_valid, imem_req_addr);
    end
    serve(1, 1'b0, 64'h0);
    checks++;
    if ({inst, inst_pc} !== {32'h00000013, 64'h8000_0004}) begin
      failures++;
      $display("FAIL basic_second got inst=%h pc=%h required 00000013/80000004", inst, inst_pc);
    end
    tick();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0008}) begin
      failures++;
      $display("FAIL basic_req3 got v=%b addr=%h required 1/80000008", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_back_to_back();
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_req[%0d] got %b required 1", i, imem_req_valid);
      end
      serve(1, 1'b0, 64'h0);
      checks++;
      if (inst_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_valid[%0d] got %b required 1", i, inst_valid);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] epc;
    inst_ready = 1'b0;
    epc = mpc;
    serve(2, 1'b0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({inst_valid, imem_req_valid, inst_pc} !== {1'b1, 1'b0, epc} || inst !== sb[0][95:64]) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b req=%b pc=%h inst=%h required 1/0/%h/%h", i, inst_valid, imem_req_valid, inst_pc, inst, epc, sb[0][95:64]);
      end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    checks++;
    if ({imem_req_valid, inst_valid} !== 2'b10) begin
      failures++;
      $display("FAIL bp_release got req=%b v=%b required 1/0", imem_req_valid, inst_valid);
    end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    imem_resp_valid = 1'b0;
    checks++;
    if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 64'h8000_0100}) begin
      failures++;
      $display("FAIL rw_drop got v=%b req=%b addr=%h required 0/1/80000100", inst_valid, imem_req_valid, imem_req_addr);
    end
    mpc = 64'h8000_0100;
    serve(1, 1'b0, 64'h0);
    checks++;
    if (inst_pc !== 64'h8000_0100) begin
      failures++;
      $display("FAIL rw_pc got %h required 80000100", inst_pc);
    end
    tick();
  endtask

  task automatic test_redirect_req();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0300;
    tick();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0300}) begin
      failures++;
      $display("FAIL rq_noready got req=%b addr=%h required 1/80000300", imem_req_valid, imem_req_addr);
    end
    redirect_pc = 64'h8000_0200;
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 64'hBAD1_BAD1_BAD1_BAD1;
    tick();
    imem_resp_valid = 1'b0;
    checks++;
    if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 64'h8000_0200}) begin
      failures++;
      $display("FAIL rq_kill got v=%b req=%b addr=%h required 0/1/80000200", inst_valid, imem_req_valid, imem_req_addr);
    end
    mpc = 64'h8000_0200;
    serve(1, 1'b0, 64'h0);
    tick();
  endtask

  task automatic test_redirect_resp();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0400;
    imem_resp_valid = 1'b1;
    imem_resp_data = 64'hBAD2_BAD2_BAD2_BAD2;
    tick();
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b0;
    checks++;
    if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 64'h8000_0400}) begin
      failures++;
      $display("FAIL rr_drop got v=%b req=%b addr=%h required 0/1/80000400", inst_valid, imem_req_valid, imem_req_addr);
    end
    mpc = 64'h8000_0400;
    serve(3, 1'b0, 64'h0);
    tick();
  endtask

  task automatic test_redirect_hold();
    logic [95:0] dropped;
    inst_ready = 1'b1;
    serve(1, 1'b0, 64'h0);
    dropped = sb.pop_back();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0102;
    halt = 1'b1;
    tick();
    redirect_valid = 1'b0;
    halt = 1'b0;
    checks++;
    if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 64'h8000_0100}) begin
      failures++;
      $display("FAIL rh_squash got v=%b req=%b addr=%h required 0/1/80000100 (dropped pc %h)", inst_valid, imem_req_valid, imem_req_addr, dropped[63:0]);
    end
    mpc = 64'h8000_0100;
    serve(1, 1'b0, 64'h0);
    checks++;
    if (inst_pc !== 64'h8000_0100) begin
      failures++;
      $display("FAIL rh_pc got %h required 80000100", inst_pc);
    end
    tick();
  endtask

  task automatic test_halt();
    inst_ready = 1'b1;
    serve(1, 1'b1, 64'h00100073_00100073);
    checks++;
    if (inst !== 32'h00100073) begin
      failures++;
      $display("FAIL halt_inst got %h required 00100073", inst);
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      redirect_valid = (i == 5);
      redirect_pc = 64'h8000_0000;
      imem_resp_valid = (i == 10);
      checks++;
      if ({imem_req_valid, inst_valid} !== 2'b00) begin
        failures++;
        $display("FAIL halt_idle[%0d] got req=%b v=%b required 0/0", i, imem_req_valid, inst_valid);
      end
      tick();
    end
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_req_valid, imem_req_addr, inst_valid, inst_pc} !== {1'b1, 64'h8000_0000, 1'b0, 64'h0}) begin
      failures++;
      $display("FAIL halt_rst got req=%b addr=%h v=%b pc=%h required 1/80000000/0/0", imem_req_valid, imem_req_addr, inst_valid, inst_pc);
    end
    tick();
    rst = 1'b0;
    mpc = 64'h8000_0000;
    serve(1, 1'b0, 64'h0);
    tick();
  endtask

  task automatic test_wrap();
    inst_ready = 1'b0;
    inst_ready2 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({req_valid2, req_addr2} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFF8}) begin
      failures++;
      $display("FAIL wrap_req got v=%b addr=%h required 1/fffffffffffffff8", req_valid2, req_addr2);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    imem_resp_valid = 1'b0;
    checks++;
    if ({inst_valid2, inst2, inst_pc2} !== {1'b1, 32'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFC}) begin
      failures++;
      $display("FAIL wrap_inst got v=%b inst=%h pc=%h required 1/deadbeef/fffffffffffffffc", inst_valid2, inst2, inst_pc2);
    end
    inst_ready2 = 1'b1;
    tick();
    checks++;
    if ({req_valid2, req_addr2} !== {1'b1, 64'h0}) begin
      failures++;
      $display("FAIL wrap_next got v=%b addr=%h required 1/0", req_valid2, req_addr2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_resp();
    test_redirect_hold();
    test_halt();
    test_wrap();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d entries required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22040125_ifu.md
# ysyx_22040125_ifu

Instruction fetch unit for the ysyx_22040125 RV64 core: owns the architectural PC, issues instruction-memory read requests, extracts the 32-bit instruction from the 64-bit read beat, and presents it with its PC to the decode stage over a valid/ready handshake. It is the producer side of the decoder's `inst` input. It accepts control-flow redirects from execute and a halt from decode (ebreak).

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000, PC loaded at reset.
- `clk`  in  1  core clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_req_addr`  out  64  {pc[63:3], 3'b000}, 8-byte aligned.
- `imem_resp_valid`  in  1  read data valid (one response per accepted request, in order).
- `imem_resp_data`  in  64  read beat.
- `inst_valid`  out  1  instruction presented to decode.
- `inst_ready`  in  1  decode consumes instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  64  PC of `inst`.
- `redirect_valid`  in  1  execute redirects fetch (jal/jalr/taken branch).
- `redirect_pc`  in  64  new PC.
- `halt`  in  1  ebreak decoded; valid only while `inst_valid && inst_ready`.

## Operation
- States: REQ, WAIT, HOLD, HALT. Internal regs: `pc`, `kill` (1 bit), output regs `inst`, `inst_pc`, `inst_valid`.
- REQ: `imem_req_valid`=1. On `imem_req_ready` -> WAIT.
- WAIT: on `imem_resp_valid`: if `kill`=0, latch `inst` = pc[2] ? data[63:32] : data[31:0], `inst_pc`=pc, `inst_valid`=1, pc<=pc+4, -> HOLD; if `kill`=1, drop data, clear `kill`, -> REQ.
- HOLD: `inst_valid`=1, outputs stable. On `inst_ready`: `inst_valid`<=0; if `halt` -> HALT else -> REQ.
- HALT: no requests, `inst_valid`=0; outstanding response (if any) absorbed and discarded. Exit only by `rst`. `redirect_valid` ignored.
- PC arithmetic: 64-bit, wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0). Redirect loads pc with redirect_pc[1:0] forced to 2'b00.
- Redirect (highest priority, any state except HALT), pc<=redirect_pc, and:
  - REQ without `imem_req_ready`: stay REQ; new address driven next cycle.
  - REQ with `imem_req_ready` same cycle: stale request accepted -> WAIT with `kill`=1.
  - WAIT, no response this cycle: `kill`<=1, stay WAIT.
  - WAIT with `imem_resp_valid` same cycle: response discarded, `kill`<=0, -> REQ.
  - HOLD: held instruction squashed regardless of `inst_ready`, `inst_valid`<=0, `halt` ignored, -> REQ.
- `imem_resp_valid` in REQ/HOLD is protocol violation; ignored.

## Timing
- Reset values: state=REQ, pc=RESET_PC, `kill`=0, `inst_valid`=0, `inst`=32'h0, `inst_pc`=0; `imem_req_valid`=1 and `imem_req_addr`=RESET_PC aligned in first cycle after reset release.
- `imem_req_valid`/`imem_req_addr` combinational from state/pc; all other outputs registered.
- Latency: request accepted cycle N, response cycle N+k (k>=1) -> `inst_valid` high cycle N+k+1.
- Peak throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with k=1 and `inst_ready` tied high.
- Redirect visible on `imem_req_addr` the cycle after `redirect_valid`.
- `rst` asserted mid-operation: immediate return to reset values; in-flight memory transaction is the memory's responsibility to reset.

## Test plan
- Reset release, memory returns 64'h00000013_00100093 at 8000_0000 -> `inst`=32'h00100093, `inst_pc`=8000_0000; next request addr 8000_0000, pc[2]=1 -> `inst`=32'h00000013, `inst_pc`=8000_0004, then addr 8000_0008.
- Backpressure: `inst_ready`=0 for 5 cycles in HOLD -> `inst`/`inst_pc` stable, `imem_req_valid`=0; release -> next request next cycle.
- Redirect in WAIT to 8000_0100 one cycle before response -> stale response dropped, no `inst_valid`, next request addr 8000_0100, then `inst_pc`=8000_0100.
- Redirect coincident with `imem_req_ready` and with `imem_resp_valid` (separate runs), and redirect in HOLD with `inst_ready`=1 -> no stale instruction ever presented; redirect_pc 8000_0102 fetches 8000_0100.
- `halt` with `inst_ready` on 32'h00100073 -> HALT, `imem_req_valid` stays 0 for 20 cycles, redirect ignored; `rst` restarts at RESET_PC.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> first `inst_pc`=…FFFC, next request addr 0.
